// File: rtl/perceptron_weight_updater.sv
// -----------------------------------------------------------------------------
// perceptron_weight_updater
//
// Training-side companion of the perceptron summing datapath. It takes one
// training sample (x1, x2, target, y, lr) and applies the perceptron learning
// rule to two weights and the bias:
//   se = (lr * (target - y)) >>> Q_N
//   w1 += (se * x1) >>> Q_N
//   w2 += (se * x2) >>> Q_N
//   b  += se
// All values are signed Q(Q_M).(Q_N) fixed point, W = SIGN + Q_M + Q_N bits.
// One multiplier and one adder are shared over a fixed schedule:
//   IDLE -> ERR -> UPD_W1 -> UPD_W2 -> UPD_B -> DONE -> IDLE
//
// Optional feature (compile-time macro WEIGHT_SAT_EN):
//   defined   : every narrowing to W bits saturates to the signed W-bit range
//   undefined : every narrowing to W bits keeps the low W bits (wrap)
//
// Ports:
//   clk_i              clock, rising edge
//   rst_i              synchronous active-high reset
//   valid_i / ready_o  sample handshake
//   x1_in, x2_in       sample inputs
//   target_in, y_in    desired and actual perceptron output
//   lr_in              learning rate
//   w1_out, w2_out     weight registers
//   b_out              bias register
//   done_o             one-cycle pulse when an update completes
//   state_dbg          current FSM state, for observation only
//
// Handshake: a sample transfers on a rising edge where valid_i && ready_o.
// ready_o is high only in IDLE and never while rst_i is high; valid_i may stay
// high while busy and is simply not looked at until the block is idle again.
// -----------------------------------------------------------------------------
module perceptron_weight_updater #(
   parameter int SIGN = 1,
   parameter int Q_M  = 16,
   parameter int Q_N  = 16,
   parameter int W    = SIGN + Q_M + Q_N
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                valid_i,
   output logic                ready_o,
   input  logic signed [W-1:0] x1_in,
   input  logic signed [W-1:0] x2_in,
   input  logic signed [W-1:0] target_in,
   input  logic signed [W-1:0] y_in,
   input  logic signed [W-1:0] lr_in,
   output logic signed [W-1:0] w1_out,
   output logic signed [W-1:0] w2_out,
   output logic signed [W-1:0] b_out,
   output logic                done_o,
   output logic [2:0]          state_dbg
);

   // Wide enough for lr (W bits) times err (W+1 bits) without loss.
   localparam int WIDE = 2 * W + 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ERR    = 3'd1,
      S_UPD_W1 = 3'd2,
      S_UPD_W2 = 3'd3,
      S_UPD_B  = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t state, state_next;

   logic signed [W-1:0]    x1_q, x2_q, target_q, y_q, lr_q, se_q;
   logic signed [W:0]      err;
   logic signed [WIDE-1:0] mul_a, mul_b, mul_p, mul_sh;
   logic signed [W-1:0]    term;
   logic signed [W-1:0]    acc, addend, sum_red;
   logic signed [WIDE-1:0] sum_wide;

   function automatic logic signed [WIDE-1:0] sext(input logic signed [W-1:0] v);
      return {{(WIDE-W){v[W-1]}}, v};
   endfunction

   // Narrow a wide signed value to W bits; the same rule is used everywhere.
   function automatic logic signed [W-1:0] reduce(input logic signed [WIDE-1:0] v);
`ifdef WEIGHT_SAT_EN
      // Value fits only if all bits above bit W-2 equal the sign bit.
      if (!v[WIDE-1] && (|v[WIDE-2:W-1]))
         return {1'b0, {(W-1){1'b1}}};
      else if (v[WIDE-1] && !(&v[WIDE-2:W-1]))
         return {1'b1, {(W-1){1'b0}}};
      else
         return v[W-1:0];
`else
      return v[W-1:0];
`endif
   endfunction

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (valid_i) state_next = S_ERR;
         S_ERR:    state_next = S_UPD_W1;
         S_UPD_W1: state_next = S_UPD_W2;
         S_UPD_W2: state_next = S_UPD_B;
         S_UPD_B:  state_next = S_DONE;
         S_DONE:   state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   assign ready_o   = (state == S_IDLE) && !rst_i;
   assign done_o    = (state == S_DONE);
   assign state_dbg = state;

   // ------------------------------------------------------------ datapath
   // Error at W+1 bits so target - y can never overflow.
   assign err = {target_q[W-1], target_q} - {y_q[W-1], y_q};

   // Shared multiplier: lr*err in ERR, se*x1 in UPD_W1, se*x2 in UPD_W2.
   always_comb begin
      mul_a = sext(se_q);
      mul_b = sext(x1_q);
      case (state)
         S_ERR: begin
            mul_a = sext(lr_q);
            mul_b = {{(WIDE-W-1){err[W]}}, err};
         end
         S_UPD_W2: mul_b = sext(x2_q);
         default: ;
      endcase
      mul_p  = mul_a * mul_b;
      mul_sh = mul_p >>> Q_N;   // arithmetic: rounds toward -infinity
      term   = reduce(mul_sh);
   end

   // Shared accumulate adder for w1, w2 and b.
   always_comb begin
      acc    = w1_out;
      addend = term;
      case (state)
         S_UPD_W2: acc = w2_out;
         S_UPD_B: begin
            acc    = b_out;
            addend = se_q;
         end
         default: ;
      endcase
      sum_wide = sext(acc) + sext(addend);
      sum_red  = reduce(sum_wide);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         x1_q     <= '0;
         x2_q     <= '0;
         target_q <= '0;
         y_q      <= '0;
         lr_q     <= '0;
         se_q     <= '0;
         w1_out   <= '0;
         w2_out   <= '0;
         b_out    <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (valid_i) begin
                  x1_q     <= x1_in;
                  x2_q     <= x2_in;
                  target_q <= target_in;
                  y_q      <= y_in;
                  lr_q     <= lr_in;
               end
            end
            S_ERR:    se_q   <= term;
            S_UPD_W1: w1_out <= sum_red;
            S_UPD_W2: w2_out <= sum_red;
            S_UPD_B:  b_out  <= sum_red;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_perceptron_weight_updater.sv
// -----------------------------------------------------------------------------
// Testbench for perceptron_weight_updater. Directed cases plus randomized
// samples; expected weights come from an arithmetic model of the learning rule
// on 128-bit integers and are queued at each accepted sample. A separate
// monitor pops and compares whenever done_o is seen. Honours WEIGHT_SAT_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_perceptron_weight_updater;

   localparam int W  = 33;
   localparam int QN = 16;

   typedef logic signed [127:0] big_t;

   localparam big_t ONE  = 128'sd1;
   localparam big_t MAXV = (ONE <<< (W-1)) - ONE;
   localparam big_t MINV = -(ONE <<< (W-1));
   localparam big_t MODV = ONE <<< W;

   // ------------------------------------------------- clock / reset / DUT
   logic clk = 1'b0;
   logic rst_i, valid_i, ready_o, done_o;
   logic signed [W-1:0] x1_in, x2_in, target_in, y_in, lr_in;
   logic signed [W-1:0] w1_out, w2_out, b_out;
   logic [2:0] state_dbg;

   always #5 clk = ~clk;

   perceptron_weight_updater dut (
      .clk_i     (clk),
      .rst_i     (rst_i),
      .valid_i   (valid_i),
      .ready_o   (ready_o),
      .x1_in     (x1_in),
      .x2_in     (x2_in),
      .target_in (target_in),
      .y_in      (y_in),
      .lr_in     (lr_in),
      .w1_out    (w1_out),
      .w2_out    (w2_out),
      .b_out     (b_out),
      .done_o    (done_o),
      .state_dbg (state_dbg)
   );

   // ---------------------------------------------------------- scoreboard
   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   logic [3*W-1:0] exp_q[$];
   big_t m_w1, m_w2, m_b;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
      end
   endtask

   // Narrowing to W bits as the learning rule defines it.
   function automatic big_t red(input big_t v);
`ifdef WEIGHT_SAT_EN
      if (v > MAXV) return MAXV;
      if (v < MINV) return MINV;
      return v;
`else
      big_t m;
      m = v % MODV;
      if (m < 0) m = m + MODV;
      if (m > MAXV) m = m - MODV;
      return m;
`endif
   endfunction

   // Apply the learning rule to the model and queue the resulting weights.
   task automatic model_apply(input logic signed [W-1:0] x1, x2, t, y, lr);
      big_t bx1, bx2, bt, by, blr, err, se;
      bx1 = x1; bx2 = x2; bt = t; by = y; blr = lr;
      err  = bt - by;
      se   = red((blr * err) >>> QN);
      m_w1 = red(m_w1 + red((se * bx1) >>> QN));
      m_w2 = red(m_w2 + red((se * bx2) >>> QN));
      m_b  = red(m_b + se);
      exp_q.push_back({m_w1[W-1:0], m_w2[W-1:0], m_b[W-1:0]});
   endtask

   // Monitor: compares the weights each time an update completes.
   initial begin
      logic [3*W-1:0] e;
      bit prev_done;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (rst_i) begin
            prev_done = 1'b0;
         end else begin
            if (done_o) begin
               done_cnt++;
               chk("mon_done_width", {32'd0, prev_done}, '0);
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL mon_spurious_done: got done_o=1 expected 0 (nothing pending)");
               end else begin
                  e = exp_q.pop_front();
                  chk("mon_w1", w1_out, e[3*W-1:2*W]);
                  chk("mon_w2", w2_out, e[2*W-1:W]);
                  chk("mon_b",  b_out,  e[W-1:0]);
               end
            end
            prev_done = done_o;
         end
      end
   end

   // ------------------------------------------------------------- drivers
   task automatic wait_ready();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (ready_o) ok = 1'b1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL ready_timeout: got ready_o=0 expected 1 within 20 cycles");
      end
   endtask

   task automatic do_reset();
      rst_i   = 1'b1;
      valid_i = 1'b0;
      exp_q.delete();
      m_w1 = 0; m_w2 = 0; m_b = 0;
      repeat (2) @(negedge clk);
      chk("rst_ready", {32'd0, ready_o}, '0);
      chk("rst_done",  {32'd0, done_o},  '0);
      chk("rst_w1", w1_out, '0);
      chk("rst_w2", w2_out, '0);
      chk("rst_b",  b_out,  '0);
      rst_i = 1'b0;
   endtask

   // Issue one sample and check the cycle-by-cycle update schedule.
   task automatic send(input logic signed [W-1:0] x1, x2, t, y, lr, input string tag);
      logic [W-1:0] o1, o2, ob, n1, n2, nb;
      wait_ready();
      x1_in = x1; x2_in = x2; target_in = t; y_in = y; lr_in = lr;
      valid_i = 1'b1;
      @(posedge clk);                       // edge k: accepted
      o1 = m_w1[W-1:0]; o2 = m_w2[W-1:0]; ob = m_b[W-1:0];
      model_apply(x1, x2, t, y, lr);
      n1 = m_w1[W-1:0]; n2 = m_w2[W-1:0]; nb = m_b[W-1:0];
      #1 valid_i = 1'b0;
      @(negedge clk);                       // after k
      chk({tag, "_ready_busy"}, {32'd0, ready_o}, '0);
      @(negedge clk);                       // after k+1
      chk({tag, "_w1_hold"}, w1_out, o1);
      @(negedge clk);                       // after k+2
      chk({tag, "_w1_new"},  w1_out, n1);
      chk({tag, "_w2_hold"}, w2_out, o2);
      @(negedge clk);                       // after k+3
      chk({tag, "_w2_new"},  w2_out, n2);
      chk({tag, "_b_hold"},  b_out,  ob);
      chk({tag, "_done_early"}, {32'd0, done_o}, '0);
      @(negedge clk);                       // after k+4
      chk({tag, "_b_new"},   b_out,  nb);
      chk({tag, "_done"},    {32'd0, done_o}, 1);
      chk({tag, "_ready_done"}, {32'd0, ready_o}, '0);
      @(negedge clk);                       // after k+5
      chk({tag, "_done_end"}, {32'd0, done_o}, '0);
      chk({tag, "_ready_back"}, {32'd0, ready_o}, 1);
   endtask

   function automatic logic signed [W-1:0] rnd_span(input int unsigned span);
      int v;
      v = int'($urandom_range(2 * span, 0)) - int'(span);
      return v;
   endfunction

   function automatic logic signed [W-1:0] rnd_full();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[W-1:0];
   endfunction

   // ------------------------------------------------------------ stimulus
   initial begin
      int n_acc, d0;
      bit acc;
      logic [W-1:0] exp_b;
      rst_i = 1'b1; valid_i = 1'b0;
      x1_in = '0; x2_in = '0; target_in = '0; y_in = '0; lr_in = '0;

      // Reset, then idle with valid low.
      do_reset();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_w1", w1_out, '0);
         chk("idle_b",  b_out,  '0);
         chk("idle_done",  {32'd0, done_o},  '0);
         chk("idle_ready", {32'd0, ready_o}, 1);
      end

      // Positive then negative update.
      send(131072, -65536, 65536, 0, 32768, "pos");
      chk("pos_w1_val", w1_out, 65536);
      chk("pos_w2_val", w2_out, -65536 / 2);
      chk("pos_b_val",  b_out,  32768);
      send(65536, 0, 0, 65536, 32768, "neg");
      chk("neg_w1_val", w1_out, 32768);
      chk("neg_w2_val", w2_out, -32768);
      chk("neg_b_val",  b_out,  0);

      // Zero error: schedule still runs, weights unchanged.
      send(rnd_span(1 << 20), rnd_span(1 << 20), 12345, 12345, 40000, "zero");
      chk("zero_w1_val", w1_out, 32768);
      chk("zero_b_val",  b_out,  0);

      // valid_i held high with new data every cycle.
      wait_ready();
      n_acc = 0;
      d0 = done_cnt;
      for (int c = 0; c < 13; c++) begin
         x1_in = rnd_span(1 << 19); x2_in = rnd_span(1 << 19);
         target_in = rnd_span(1 << 18); y_in = rnd_span(1 << 18);
         lr_in = $urandom_range(65536, 0);
         valid_i = 1'b1;
         acc = ready_o;
         @(posedge clk);
         if (acc) begin
            model_apply(x1_in, x2_in, target_in, y_in, lr_in);
            n_acc++;
         end
         @(negedge clk);
      end
      valid_i = 1'b0;
      repeat (8) @(negedge clk);
      chk("hold_done_count", W'(done_cnt - d0), W'(n_acc));

      // Random samples: moderate range and full range.
      for (int i = 0; i < 12; i++)
         send(rnd_span(1 << 20), rnd_span(1 << 20), rnd_span(1 << 20),
              rnd_span(1 << 20), $urandom_range(131072, 0), "rnd");
      for (int i = 0; i < 6; i++)
         send(rnd_full(), rnd_full(), rnd_full(), rnd_full(), rnd_full(), "rndfull");

      // Reset while in UPD_W2.
      wait_ready();
      x1_in = 65536; x2_in = 65536; target_in = 65536; y_in = 0; lr_in = 65536;
      valid_i = 1'b1;
      @(posedge clk);
      #1 valid_i = 1'b0;
      repeat (3) @(negedge clk);            // now in UPD_W2
      rst_i = 1'b1;
      exp_q.delete();
      m_w1 = 0; m_w2 = 0; m_b = 0;
      @(negedge clk);
      chk("midrst_w1", w1_out, '0);
      chk("midrst_w2", w2_out, '0);
      chk("midrst_b",  b_out,  '0);
      chk("midrst_done",  {32'd0, done_o},  '0);
      chk("midrst_ready", {32'd0, ready_o}, '0);
      rst_i = 1'b0;
      #1;
      chk("midrst_ready_after", {32'd0, ready_o}, 1);
      repeat (6) @(negedge clk);

      // Overflow of se into the bias.
      send(0, 0, 33'sd2147483648, -33'sd2147483648, 65536, "ovf");
`ifdef WEIGHT_SAT_EN
      exp_b = 33'h0_FFFF_FFFF;
`else
      exp_b = 33'h1_0000_0000;
`endif
      chk("ovf_b_val",  b_out,  exp_b);
      chk("ovf_w1_val", w1_out, '0);
      chk("ovf_w2_val", w2_out, '0);

      repeat (4) @(negedge clk);
      chk("queue_empty", W'(exp_q.size()), '0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
